// File: rtl/multicycle_control_fsm.sv
// Multi-cycle RV32I sequencer: steps shared ALU, memory port and regfile
// through fetch/decode/execute/memory/writeback and counts retirements.
module multicycle_control_fsm #(
    parameter int instr_width = 32,
    parameter int cnt_width   = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [instr_width-1:0] instr,
    input  logic                   EQ,
    input  logic                   mem_ready,
    output logic                   IRWrite,
    output logic                   PCWrite,
    output logic                   PCsrc,
    output logic                   AdrSrc,
    output logic                   MemRead,
    output logic                   MemWrite,
    output logic                   RegWrite,
    output logic                   ALUsrc,
    output logic [2:0]             ALUctrl,
    output logic [1:0]             ImmSrc,
    output logic                   ResultSrc,
    output logic                   illegal,
    output logic [2:0]             state,
    output logic [cnt_width-1:0]   instret
);

    typedef enum logic [2:0] {
        FETCH     = 3'd0,
        DECODE    = 3'd1,
        EXEC_ALU  = 3'd2,
        EXEC_BR   = 3'd3,
        MEM_ADDR  = 3'd4,
        MEM_READ  = 3'd5,
        MEM_WRITE = 3'd6,
        WRITEBACK = 3'd7
    } state_t;

    state_t st;

    logic [6:0] op;
    logic [2:0] f3;
    logic       f7b5;
    logic       is_imm, is_reg, is_br, is_load, is_store;
    logic       taken;
    logic       unused_bits;

    assign op       = instr[6:0];
    assign f3       = instr[14:12];
    assign f7b5     = instr[30];
    assign is_imm   = (op == 7'b0010011);
    assign is_reg   = (op == 7'b0110011);
    assign is_br    = (op == 7'b1100011);
    assign is_load  = (op == 7'b0000011);
    assign is_store = (op == 7'b0100011);
    assign taken    = ((f3 == 3'b000) && EQ) || ((f3 == 3'b001) && !EQ);
    assign state    = st;

    assign unused_bits = ^{instr[instr_width-1:31], instr[29:15], instr[11:7]};

    always_ff @(posedge clk) begin
        if (rst) begin
            st      <= FETCH;
            instret <= '0;
        end else begin
            unique case (st)
                FETCH:
                    if (mem_ready) st <= DECODE;
                DECODE: begin
                    unique case (1'b1)
                        is_imm || is_reg:    st <= EXEC_ALU;
                        is_br:               st <= EXEC_BR;
                        is_load || is_store: st <= MEM_ADDR;
                        default:             st <= FETCH;
                    endcase
                end
                EXEC_ALU:
                    st <= WRITEBACK;
                EXEC_BR: begin
                    instret <= instret + cnt_width'(1);
                    st      <= FETCH;
                end
                MEM_ADDR:
                    st <= is_load ? MEM_READ : MEM_WRITE;
                MEM_READ:
                    if (mem_ready) st <= WRITEBACK;
                MEM_WRITE:
                    if (mem_ready) begin
                        instret <= instret + cnt_width'(1);
                        st      <= FETCH;
                    end
                WRITEBACK: begin
                    instret <= instret + cnt_width'(1);
                    st      <= FETCH;
                end
                default:
                    st <= FETCH;
            endcase
        end
    end

    always_comb begin
        IRWrite   = 1'b0;
        PCWrite   = 1'b0;
        PCsrc     = 1'b0;
        AdrSrc    = 1'b0;
        MemRead   = 1'b0;
        MemWrite  = 1'b0;
        RegWrite  = 1'b0;
        ALUsrc    = 1'b0;
        ALUctrl   = 3'b000;
        ImmSrc    = 2'b00;
        ResultSrc = 1'b0;
        illegal   = 1'b0;
        unique case (st)
            FETCH: begin
                MemRead = 1'b1;
                if (mem_ready) begin
                    IRWrite = 1'b1;
                    PCWrite = 1'b1;
                end
            end
            DECODE:
                illegal = !(is_imm || is_reg || is_br || is_load || is_store);
            EXEC_ALU: begin
                ALUsrc = is_imm;
                unique case (f3)
                    3'b000:  ALUctrl = (is_reg && f7b5) ? 3'b001 : 3'b000;
                    3'b111:  ALUctrl = 3'b010;
                    3'b110:  ALUctrl = 3'b011;
                    3'b010:  ALUctrl = 3'b101;
                    default: ALUctrl = 3'b000;
                endcase
            end
            EXEC_BR: begin
                ALUctrl = 3'b001;
                ImmSrc  = 2'b10;
                if (taken) begin
                    PCWrite = 1'b1;
                    PCsrc   = 1'b1;
                end
            end
            MEM_ADDR: begin
                ALUsrc = 1'b1;
                ImmSrc = is_store ? 2'b01 : 2'b00;
            end
            MEM_READ: begin
                AdrSrc  = 1'b1;
                MemRead = 1'b1;
            end
            MEM_WRITE: begin
                AdrSrc   = 1'b1;
                MemWrite = 1'b1;
            end
            WRITEBACK: begin
                RegWrite  = 1'b1;
                ResultSrc = is_load;
            end
            default: ;
        endcase
        // Reset must abort any in-flight access without side effects
        if (rst) begin
            IRWrite  = 1'b0;
            PCWrite  = 1'b0;
            MemRead  = 1'b0;
            MemWrite = 1'b0;
            RegWrite = 1'b0;
            illegal  = 1'b0;
        end
    end

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Directed bench for multicycle_control_fsm: per-cycle state and
// control-word checks against hand-computed vectors.
module tb_multicycle_control_fsm;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] instr;
    logic        EQ;
    logic        mem_ready;
    logic        IRWrite, PCWrite, PCsrc, AdrSrc, MemRead, MemWrite;
    logic        RegWrite, ALUsrc, ResultSrc, illegal;
    logic [2:0]  ALUctrl;
    logic [1:0]  ImmSrc;
    logic [2:0]  state;
    logic [31:0] instret;
    logic [14:0] ctl;

    int total = 0;
    int bad   = 0;
    int ret   = 0;

    // IR PC PCs Adr MR MW RW AS ALU Imm RS ILL
    localparam logic [14:0] C_FET  = 15'b1_1_0_0_1_0_0_0_000_00_0_0;
    localparam logic [14:0] C_FETW = 15'b0_0_0_0_1_0_0_0_000_00_0_0;
    localparam logic [14:0] C_DEC  = 15'b0_0_0_0_0_0_0_0_000_00_0_0;
    localparam logic [14:0] C_ILL  = 15'b0_0_0_0_0_0_0_0_000_00_0_1;
    localparam logic [14:0] C_ADDI = 15'b0_0_0_0_0_0_0_1_000_00_0_0;
    localparam logic [14:0] C_SUB  = 15'b0_0_0_0_0_0_0_0_001_00_0_0;
    localparam logic [14:0] C_AND  = 15'b0_0_0_0_0_0_0_0_010_00_0_0;
    localparam logic [14:0] C_ORI  = 15'b0_0_0_0_0_0_0_1_011_00_0_0;
    localparam logic [14:0] C_SLTI = 15'b0_0_0_0_0_0_0_1_101_00_0_0;
    localparam logic [14:0] C_WB   = 15'b0_0_0_0_0_0_1_0_000_00_0_0;
    localparam logic [14:0] C_WBL  = 15'b0_0_0_0_0_0_1_0_000_00_1_0;
    localparam logic [14:0] C_BRT  = 15'b0_1_1_0_0_0_0_0_001_10_0_0;
    localparam logic [14:0] C_BRN  = 15'b0_0_0_0_0_0_0_0_001_10_0_0;
    localparam logic [14:0] C_MAL  = 15'b0_0_0_0_0_0_0_1_000_00_0_0;
    localparam logic [14:0] C_MAS  = 15'b0_0_0_0_0_0_0_1_000_01_0_0;
    localparam logic [14:0] C_MRD  = 15'b0_0_0_1_1_0_0_0_000_00_0_0;
    localparam logic [14:0] C_MWR  = 15'b0_0_0_1_0_1_0_0_000_00_0_0;
    localparam logic [14:0] C_MWRR = 15'b0_0_0_1_0_0_0_0_000_00_0_0;

    assign ctl = {IRWrite, PCWrite, PCsrc, AdrSrc, MemRead, MemWrite,
                  RegWrite, ALUsrc, ALUctrl, ImmSrc, ResultSrc, illegal};

    multicycle_control_fsm #(.instr_width(32), .cnt_width(32)) dut (
        .clk      (clk),
        .rst      (rst),
        .instr    (instr),
        .EQ       (EQ),
        .mem_ready(mem_ready),
        .IRWrite  (IRWrite),
        .PCWrite  (PCWrite),
        .PCsrc    (PCsrc),
        .AdrSrc   (AdrSrc),
        .MemRead  (MemRead),
        .MemWrite (MemWrite),
        .RegWrite (RegWrite),
        .ALUsrc   (ALUsrc),
        .ALUctrl  (ALUctrl),
        .ImmSrc   (ImmSrc),
        .ResultSrc(ResultSrc),
        .illegal  (illegal),
        .state    (state),
        .instret  (instret)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        mem_ready = 1'b1;
        EQ = 1'b0;
        instr = 32'h00500093;
        tick();
        #1;
        total++;
        if ({state, ctl, instret} !== {3'd0, 15'd0, 32'd0}) begin
            bad++;
            $display("FAIL reset got st=%0d ctl=%b ret=%0d want st=0 ctl=0 ret=0",
                     state, ctl, instret);
        end
        rst = 1'b0;
        ret = 0;
    endtask

    task automatic test_addi;
        logic [17:0] ex [4];
        ex = '{{3'd0, C_FET}, {3'd1, C_DEC}, {3'd2, C_ADDI}, {3'd7, C_WB}};
        instr = 32'h00500093;
        mem_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            total++;
            if ({state, ctl} !== ex[i]) begin
                bad++;
                $display("FAIL addi c%0d got=%h want=%h", i, {state, ctl}, ex[i]);
            end
            tick();
        end
        ret++;
        total++;
        if ({state, instret} !== {3'd0, 32'(ret)}) begin
            bad++;
            $display("FAIL addi_ret got st=%0d ret=%0d want st=0 ret=%0d",
                     state, instret, ret);
        end
    endtask

    task automatic test_alu_ops;
        logic [31:0] ins [4];
        logic [14:0] ec  [4];
        logic [17:0] ex  [4];
        ins = '{32'h402081B3, 32'h0020F1B3, 32'h0060E093, 32'h0050A093};
        ec  = '{C_SUB, C_AND, C_ORI, C_SLTI};
        mem_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            instr = ins[k];
            ex = '{{3'd0, C_FET}, {3'd1, C_DEC}, {3'd2, ec[k]}, {3'd7, C_WB}};
            for (int i = 0; i < 4; i++) begin
                #1;
                total++;
                if ({state, ctl} !== ex[i]) begin
                    bad++;
                    $display("FAIL alu%0d c%0d got=%h want=%h",
                             k, i, {state, ctl}, ex[i]);
                end
                tick();
            end
            ret++;
        end
        total++;
        if (instret !== 32'(ret)) begin
            bad++;
            $display("FAIL alu_ret got=%0d want=%0d", instret, ret);
        end
    endtask

    task automatic test_branch;
        logic [31:0] ins [3];
        logic        eqv [3];
        logic [14:0] ec  [3];
        logic [17:0] ex  [3];
        ins = '{32'h00209463, 32'h00209463, 32'h00208463};
        eqv = '{1'b0, 1'b1, 1'b1};
        ec  = '{C_BRT, C_BRN, C_BRT};
        mem_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            instr = ins[k];
            EQ = eqv[k];
            ex = '{{3'd0, C_FET}, {3'd1, C_DEC}, {3'd3, ec[k]}};
            for (int i = 0; i < 3; i++) begin
                #1;
                total++;
                if ({state, ctl} !== ex[i]) begin
                    bad++;
                    $display("FAIL br%0d c%0d got=%h want=%h",
                             k, i, {state, ctl}, ex[i]);
                end
                tick();
            end
            ret++;
            total++;
            if ({state, instret} !== {3'd0, 32'(ret)}) begin
                bad++;
                $display("FAIL br%0d_ret got st=%0d ret=%0d want st=0 ret=%0d",
                         k, state, instret, ret);
            end
        end
        EQ = 1'b0;
    endtask

    task automatic test_load;
        logic [17:0] ex [8];
        logic [7:0]  rdy;
        ex = '{{3'd0, C_FET}, {3'd1, C_DEC}, {3'd4, C_MAL},
               {3'd5, C_MRD}, {3'd5, C_MRD}, {3'd5, C_MRD},
               {3'd5, C_MRD}, {3'd7, C_WBL}};
        rdy = 8'b11000111;
        instr = 32'h0000A283;
        for (int i = 0; i < 8; i++) begin
            mem_ready = rdy[i];
            #1;
            total++;
            if ({state, ctl} !== ex[i]) begin
                bad++;
                $display("FAIL lw c%0d got=%h want=%h", i, {state, ctl}, ex[i]);
            end
            tick();
        end
        ret++;
        total++;
        if ({state, instret} !== {3'd0, 32'(ret)}) begin
            bad++;
            $display("FAIL lw_ret got st=%0d ret=%0d want st=0 ret=%0d",
                     state, instret, ret);
        end
    endtask

    task automatic test_store;
        logic [17:0] ex [6];
        logic [5:0]  rdy;
        ex = '{{3'd0, C_FETW}, {3'd0, C_FET}, {3'd1, C_DEC},
               {3'd4, C_MAS}, {3'd6, C_MWR}, {3'd6, C_MWR}};
        rdy = 6'b101110;
        instr = 32'h0050A023;
        for (int i = 0; i < 6; i++) begin
            mem_ready = rdy[i];
            #1;
            total++;
            if ({state, ctl} !== ex[i]) begin
                bad++;
                $display("FAIL sw c%0d got=%h want=%h", i, {state, ctl}, ex[i]);
            end
            tick();
        end
        ret++;
        total++;
        if ({state, instret} !== {3'd0, 32'(ret)}) begin
            bad++;
            $display("FAIL sw_ret got st=%0d ret=%0d want st=0 ret=%0d",
                     state, instret, ret);
        end
    endtask

    task automatic test_illegal;
        logic [17:0] ex [3];
        logic [2:0]  rdy;
        ex = '{{3'd0, C_FET}, {3'd1, C_ILL}, {3'd0, C_FETW}};
        rdy = 3'b011;
        instr = 32'h0000007F;
        for (int i = 0; i < 3; i++) begin
            mem_ready = rdy[i];
            #1;
            total++;
            if ({state, ctl} !== ex[i]) begin
                bad++;
                $display("FAIL ill c%0d got=%h want=%h", i, {state, ctl}, ex[i]);
            end
            tick();
        end
        total++;
        if (instret !== 32'(ret)) begin
            bad++;
            $display("FAIL ill_ret got=%0d want=%0d", instret, ret);
        end
    endtask

    task automatic test_reset_mid;
        logic [17:0] ex [4];
        logic [3:0]  rdy;
        ex = '{{3'd0, C_FET}, {3'd1, C_DEC}, {3'd4, C_MAS}, {3'd6, C_MWR}};
        rdy = 4'b0111;
        instr = 32'h0050A023;
        for (int i = 0; i < 4; i++) begin
            mem_ready = rdy[i];
            #1;
            total++;
            if ({state, ctl} !== ex[i]) begin
                bad++;
                $display("FAIL rstmid c%0d got=%h want=%h", i, {state, ctl}, ex[i]);
            end
            tick();
        end
        rst = 1'b1;
        #1;
        total++;
        if ({state, ctl} !== {3'd6, C_MWRR}) begin
            bad++;
            $display("FAIL rstmid_abort got=%h want=%h",
                     {state, ctl}, {3'd6, C_MWRR});
        end
        tick();
        total++;
        if ({state, instret} !== {3'd0, 32'd0}) begin
            bad++;
            $display("FAIL rstmid_after got st=%0d ret=%0d want st=0 ret=0",
                     state, instret);
        end
        rst = 1'b0;
        ret = 0;
    endtask

    task automatic test_back_to_back;
        test_addi();
        test_addi();
    endtask

    initial begin
        test_reset();
        test_addi();
        test_alu_ops();
        test_branch();
        test_load();
        test_store();
        test_illegal();
        test_reset_mid();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/multicycle_control_fsm.md
Name: multicycle_control_fsm

Overview:
Multi-cycle sequencer for the RV32I datapath. It replaces single-cycle decode with an FSM that steps a shared ALU, shared instruction/data memory port and register file through fetch, decode, execute, memory and writeback. It supports addi-class I-type, R-type ALU, lw, sw, beq and bne, handshakes with a variable-latency memory via mem_ready, and counts retired instructions.

Parameters:
instr_width, 32, width of the instruction register contents presented on instr
cnt_width, 32, width of the retired-instruction counter

Ports:
clk  input  1  system clock, all state updates on rising edge
rst  input  1  synchronous, active-high reset
instr  input  instr_width  current instruction register contents (opcode [6:0], funct3 [14:12], funct7[5] = bit 30)
EQ  input  1  ALU zero flag from the current cycle's ALU operation
mem_ready  input  1  memory port completes the current access this cycle
IRWrite  output  1  load instruction register from memory read data
PCWrite  output  1  update PC
PCsrc  output  1  0: PC+4; 1: OldPC+ImmB
AdrSrc  output  1  memory address select; 0: PC, 1: ALU result register
MemRead  output  1  memory read request
MemWrite  output  1  memory write request
RegWrite  output  1  register file write enable
ALUsrc  output  1  0: rs2; 1: immediate
ALUctrl  output  3  000 add, 001 sub, 010 and, 011 or, 101 slt
ImmSrc  output  2  00 I-type, 01 S-type, 10 B-type
ResultSrc  output  1  writeback select; 0: ALU result, 1: memory read data
illegal  output  1  one-cycle pulse on an unsupported opcode
state  output  3  current FSM state for debug
instret  output  cnt_width  retired-instruction count

Behaviour:
- States: FETCH=0, DECODE=1, EXEC_ALU=2, EXEC_BR=3, MEM_ADDR=4, MEM_READ=5, MEM_WRITE=6, WRITEBACK=7. State is registered. Outputs are combinational from state, instr and EQ, and default to 0 in every state unless listed.
- Reset: while rst=1, all enables and requests (IRWrite, PCWrite, MemRead, MemWrite, RegWrite) are forced to 0 and illegal=0. On the next edge state=FETCH and instret=0. Reset mid-access aborts it with no write.
- FETCH: AdrSrc=0, MemRead=1. Hold while mem_ready=0. When mem_ready=1: IRWrite=1, PCWrite=1, PCsrc=0, then go to DECODE.
- DECODE: one cycle, no enables. Next state by opcode:
  - 0010011 or 0110011 -> EXEC_ALU
  - 1100011 -> EXEC_BR
  - 0000011 or 0100011 -> MEM_ADDR
  - anything else -> FETCH with illegal=1 for this cycle
- EXEC_ALU: ALUsrc=1 for I-type, 0 for R-type; ImmSrc=00.
  - ALUctrl by funct3: 000 add (sub only when R-type and funct7[5]=1), 111 and, 110 or, 010 slt. Other funct3 values use add.
  - Next state WRITEBACK.
- WRITEBACK: RegWrite=1; ResultSrc=1 if opcode=0000011, else 0. Increment instret, then go to FETCH.
- EXEC_BR: ALUsrc=0, ALUctrl=001, ImmSrc=10.
  - taken = (funct3=000 & EQ) | (funct3=001 & ~EQ); other funct3 values are never taken.
  - If taken: PCWrite=1, PCsrc=1.
  - Increment instret, then go to FETCH.
- MEM_ADDR: ALUsrc=1, ALUctrl=000, ImmSrc=00 for load, 01 for store. Next state MEM_READ (load) or MEM_WRITE (store).
- MEM_READ: AdrSrc=1, MemRead=1. Hold until mem_ready=1, then go to WRITEBACK.
- MEM_WRITE: AdrSrc=1, MemWrite=1. Hold until mem_ready=1; on completion increment instret and go to FETCH.
- Latency with mem_ready tied to 1: ALU 4 cycles, branch 3, load 5, store 4.
- MemRead and MemWrite are never both 1. RegWrite and MemWrite are never both 1.
- instret wraps modulo 2^cnt_width. Illegal opcodes do not increment it.

Test Plan:
- Reset then addi (0x00500093), mem_ready=1 -> states 0,1,2,7,0; RegWrite=1 only in state 7; ALUctrl=000, ALUsrc=1; instret=1.
- R-type sub (funct7[5]=1, funct3=000) -> ALUctrl=001, ALUsrc=0 in EXEC_ALU; RegWrite=1 in WRITEBACK with ResultSrc=0.
- bne with EQ=0 -> PCWrite=1, PCsrc=1 in EXEC_BR. Same instruction with EQ=1 -> PCWrite=0. beq with EQ=1 -> taken. instret increments in all three cases.
- lw with mem_ready low for 3 cycles in MEM_READ -> MemRead and AdrSrc stay 1 for 4 cycles; WRITEBACK has ResultSrc=1, RegWrite=1. sw -> MemWrite=1 until mem_ready, no RegWrite.
- Opcode 0x7F -> illegal pulses 1 cycle in DECODE, next state FETCH, instret unchanged, no write enables.
- rst asserted during MEM_WRITE stall -> MemWrite=0 that cycle, state=FETCH and instret=0 after the edge.
